spi_master_ctl: RTL and testbench

SPI master sequencer sitting behind the Wishbone register slave. It takes the software-visible transmit word, chip-select index and start bit, runs one 32-bit full-duplex mode-0 SPI transfer on the selected device, returns the received word, and raises a sticky done flag that software polls. Only one transfer runs at a time; start requests arriving while a transfer is in progress are dropped.

---
 rtl/spi_master_ctl.sv | 163 ++++++++++++++++
 tb/tb_spi_master_ctl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_ctl.sv
// Single-transfer, 32-bit, mode-0 SPI master sequencer with a sticky done flag.
// Optional build macro SPI_CTL_LSB_FIRST_EN selects LSB-first shifting (default MSB-first).
module spi_master_ctl #(
   parameter int CLK_DIV = 4,
   parameter int N_CS    = 4
) (
   input  logic            clk_i,
   input  logic            reset_n_i,
   input  logic            start_i,
   input  logic [31:0]     data_i,
   input  logic [1:0]      sel_i,
   output logic [31:0]     data_o,
   output logic            done_o,
   output logic            busy_o,
   output logic            sclk_o,
   output logic            mosi_o,
   input  logic            miso_i,
   output logic [N_CS-1:0] cs_n_o
);

   localparam int DIV_W = $clog2(CLK_DIV) + 1;
   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [5:0]       HALF_LAST = 6'd63;

   typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

   state_t            state_q, state_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic [5:0]        half_q, half_d;
   logic [31:0]       shift_q, shift_d;
   logic [31:0]       data_q, data_d;
   logic [N_CS-1:0]   cs_n_q, cs_n_d;
   logic              sclk_q, sclk_d;
   logic              mosi_q, mosi_d;
   logic              done_q, done_d;
   logic              start_dly_q;
   logic              div_last;

`ifdef SPI_CTL_LSB_FIRST_EN
   function automatic logic first_bit(input logic [31:0] w);
      return w[0];
   endfunction
   function automatic logic [31:0] shift_in(input logic [31:0] w, input logic b);
      return {b, w[31:1]};
   endfunction
`else
   function automatic logic first_bit(input logic [31:0] w);
      return w[31];
   endfunction
   function automatic logic [31:0] shift_in(input logic [31:0] w, input logic b);
      return {w[30:0], b};
   endfunction
`endif

   // Delay flop resets high so a start level held through reset is not seen as an edge.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q     <= IDLE;
         div_q       <= '0;
         half_q      <= '0;
         shift_q     <= '0;
         data_q      <= '0;
         cs_n_q      <= '1;
         sclk_q      <= 1'b0;
         mosi_q      <= 1'b0;
         done_q      <= 1'b0;
         start_dly_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         div_q       <= div_d;
         half_q      <= half_d;
         shift_q     <= shift_d;
         data_q      <= data_d;
         cs_n_q      <= cs_n_d;
         sclk_q      <= sclk_d;
         mosi_q      <= mosi_d;
         done_q      <= done_d;
         start_dly_q <= start_i;
      end
   end

   assign div_last = (div_q == DIV_LAST);

   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      half_d  = half_q;
      shift_d = shift_q;
      data_d  = data_q;
      cs_n_d  = cs_n_q;
      sclk_d  = sclk_q;
      mosi_d  = mosi_q;
      done_d  = done_q;
      unique case (state_q)
         IDLE: begin
            if (start_i && !start_dly_q) begin
               state_d = SETUP;
               div_d   = '0;
               shift_d = data_i;
               done_d  = 1'b0;
               sclk_d  = 1'b0;
               mosi_d  = first_bit(data_i);
               cs_n_d  = '1;
               for (int i = 0; i < N_CS; i++) begin
                  if (int'(sel_i) == i) cs_n_d[i] = 1'b0;
               end
            end
         end
         SETUP: begin
            if (div_last) begin
               state_d = SHIFT;
               div_d   = '0;
               half_d  = '0;
               sclk_d  = 1'b1;
               shift_d = shift_in(shift_q, miso_i);
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
         // Half-period index 63 is the final low phase; its falling edge leaves mosi alone.
         SHIFT: begin
            if (!div_last) begin
               div_d = div_q + DIV_W'(1);
            end else begin
               div_d = '0;
               if (half_q == HALF_LAST) begin
                  state_d = HOLD;
               end else begin
                  half_d = half_q + 6'd1;
                  if (sclk_q) begin
                     sclk_d = 1'b0;
                     if (half_q != HALF_LAST - 6'd1) mosi_d = first_bit(shift_q);
                  end else begin
                     sclk_d  = 1'b1;
                     shift_d = shift_in(shift_q, miso_i);
                  end
               end
            end
         end
         HOLD: begin
            if (div_last) begin
               state_d = IDLE;
               div_d   = '0;
               cs_n_d  = '1;
               mosi_d  = 1'b0;
               data_d  = shift_q;
               done_d  = 1'b1;
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign data_o = data_q;
   assign done_o = done_q;
   assign busy_o = (state_q != IDLE);
   assign sclk_o = sclk_q;
   assign mosi_o = mosi_q;
   assign cs_n_o = cs_n_q;

endmodule

// File: tb/tb_spi_master_ctl.sv
// Bench for spi_master_ctl: table of transfers plus random words, checked against
// a bit-level model of what the SPI wire should carry and when.
module tb_spi_master_ctl;

   localparam int CLK_DIV = 4;
   localparam int N_CS    = 4;
   localparam int XFER    = 66 * CLK_DIV;

   logic            clk_i = 1'b0;
   logic            reset_n_i;
   logic            start_i;
   logic [31:0]     data_i;
   logic [1:0]      sel_i;
   logic [31:0]     data_o;
   logic            done_o;
   logic            busy_o;
   logic            sclk_o;
   logic            mosi_o;
   logic            miso_i;
   logic [N_CS-1:0] cs_n_o;

   logic            loop_mode = 1'b0;
   logic            miso_pat  = 1'b0;
   int              checks = 0;
   int              errors = 0;

   typedef struct {
      logic [31:0]     tx;
      logic [1:0]      sel;
      logic [31:0]     pat;
      logic            loop;
      logic [31:0]     exp_data;
      logic [N_CS-1:0] exp_cs;
   } vec_t;

   vec_t vecs[6];

   spi_master_ctl #(.CLK_DIV(CLK_DIV), .N_CS(N_CS)) dut (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .start_i   (start_i),
      .data_i    (data_i),
      .sel_i     (sel_i),
      .data_o    (data_o),
      .done_o    (done_o),
      .busy_o    (busy_o),
      .sclk_o    (sclk_o),
      .mosi_o    (mosi_o),
      .miso_i    (miso_i),
      .cs_n_o    (cs_n_o)
   );

   always #5 clk_i = ~clk_i;

   assign miso_i = loop_mode ? mosi_o : miso_pat;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [31:0] d, input logic [1:0] s, input logic st);
      data_i  = d;
      sel_i   = s;
      start_i = st;
   endtask

   function automatic logic [N_CS-1:0] csFor(input logic [1:0] s);
      logic [N_CS-1:0] r;
      r = '1;
      if (int'(s) < N_CS) r[s] = 1'b0;
      return r;
   endfunction

   // Word bit carried by the k-th SCLK pulse on the wire.
   function automatic int bitPos(input int k);
`ifdef SPI_CTL_LSB_FIRST_EN
      return k;
`else
      return 31 - k;
`endif
   endfunction

   task automatic runTransfer(input vec_t v, input bit toggle_mid, input bit hold_start);
      int          rises = 0;
      int          high = 0;
      int          busy_cnt = 0;
      int          cs_bad = 0;
      int          done_early = 0;
      int          first_rise = 0;
      logic [31:0] cap = '0;
      logic        prev_sclk = 1'b0;
      @(negedge clk_i);
      applyStimulus(v.tx, v.sel, 1'b0);
      loop_mode = v.loop;
      miso_pat  = v.pat[bitPos(0)];
      @(negedge clk_i);
      start_i = 1'b1;
      @(posedge clk_i);
      for (int n = 1; n <= XFER + 1; n++) begin
         @(negedge clk_i);
         if (n == 1) begin
            checkOutput("cs_at_accept", 32'(cs_n_o), 32'(v.exp_cs));
            checkOutput("busy_at_accept", 32'(busy_o), 32'd1);
            checkOutput("done_cleared", 32'(done_o), 32'd0);
         end
         if (n <= XFER) begin
            if (busy_o) busy_cnt++;
            if (cs_n_o !== v.exp_cs) cs_bad++;
            if (done_o) done_early++;
            if (sclk_o) high++;
            if (sclk_o && !prev_sclk) begin
               if (rises == 0) first_rise = n;
               if (rises < 32) cap[bitPos(rises)] = mosi_o;
               rises++;
            end
            prev_sclk = sclk_o;
            if (rises < 32) miso_pat = v.pat[bitPos(rises)];
         end else begin
            checkOutput("done_at_end", 32'(done_o), 32'd1);
            checkOutput("busy_at_end", 32'(busy_o), 32'd0);
            checkOutput("cs_released", 32'(cs_n_o), 32'(csFor(2'd0) | {N_CS{1'b1}}));
            checkOutput("data_o", data_o, v.exp_data);
            checkOutput("mosi_idle", 32'(mosi_o), 32'd0);
            checkOutput("sclk_idle", 32'(sclk_o), 32'd0);
         end
         if (n == 2 && !hold_start) applyStimulus($urandom, 2'($urandom_range(0, 3)), 1'b0);
         if (toggle_mid && n == 100) start_i = 1'b0;
         if (toggle_mid && n == 101) start_i = 1'b1;
         if (toggle_mid && n == 110 && !hold_start) start_i = 1'b0;
      end
      checkOutput("sclk_pulses", 32'(rises), 32'd32);
      checkOutput("sclk_high_cycles", 32'(high), 32'(32 * CLK_DIV));
      checkOutput("first_rise_cycle", 32'(first_rise), 32'(1 + CLK_DIV));
      checkOutput("mosi_word", cap, v.tx);
      checkOutput("busy_cycles", 32'(busy_cnt), 32'(XFER));
      checkOutput("cs_glitches", 32'(cs_bad), 32'd0);
      checkOutput("done_early", 32'(done_early), 32'd0);
   endtask

   initial begin
      int busy_seen;
      int done_low;

      vecs[0].tx = 32'hA5C30F81; vecs[0].sel = 2'd2; vecs[0].pat = 32'h0;        vecs[0].loop = 1'b1;
      vecs[1].tx = 32'h00000000; vecs[1].sel = 2'd0; vecs[1].pat = 32'hFFFFFFFF; vecs[1].loop = 1'b0;
      vecs[2].tx = 32'h00000001; vecs[2].sel = 2'd3; vecs[2].pat = 32'h0;        vecs[2].loop = 1'b1;
      for (int i = 3; i < 6; i++) begin
         vecs[i].tx   = $urandom;
         vecs[i].sel  = 2'($urandom_range(0, 3));
         vecs[i].pat  = $urandom;
         vecs[i].loop = 1'($urandom_range(0, 1));
      end
      for (int i = 0; i < 6; i++) begin
         vecs[i].exp_data = vecs[i].loop ? vecs[i].tx : vecs[i].pat;
         vecs[i].exp_cs   = csFor(vecs[i].sel);
      end

      reset_n_i = 1'b0;
      applyStimulus(32'h12345678, 2'd1, 1'b1);
      repeat (3) @(negedge clk_i);
      checkOutput("reset_cs", 32'(cs_n_o), 32'hF);
      checkOutput("reset_sclk", 32'(sclk_o), 32'd0);
      checkOutput("reset_done", 32'(done_o), 32'd0);
      checkOutput("reset_busy", 32'(busy_o), 32'd0);
      checkOutput("reset_data", data_o, 32'd0);
      reset_n_i = 1'b1;
      busy_seen = 0;
      repeat (20) begin
         @(negedge clk_i);
         if (busy_o || cs_n_o !== 4'hF) busy_seen++;
      end
      checkOutput("no_start_after_reset", 32'(busy_seen), 32'd0);

      for (int i = 0; i < 6; i++) runTransfer(vecs[i], 1'b0, 1'b0);

      // Mid-transfer edge ignored, then start held high after completion.
      runTransfer(vecs[0], 1'b1, 1'b1);
      busy_seen = 0;
      done_low  = 0;
      repeat (20) begin
         @(negedge clk_i);
         if (busy_o) busy_seen++;
         if (!done_o) done_low++;
      end
      checkOutput("held_start_no_restart", 32'(busy_seen), 32'd0);
      checkOutput("done_sticky", 32'(done_low), 32'd0);

      start_i = 1'b0;
      @(negedge clk_i);
      start_i = 1'b1;
      @(posedge clk_i);
      @(negedge clk_i);
      checkOutput("fresh_edge_clears_done", 32'(done_o), 32'd0);
      checkOutput("fresh_edge_busy", 32'(busy_o), 32'd1);

      // Asynchronous reset in the middle of that transfer.
      repeat (99) @(negedge clk_i);
      reset_n_i = 1'b0;
      #1;
      checkOutput("midreset_cs", 32'(cs_n_o), 32'hF);
      checkOutput("midreset_sclk", 32'(sclk_o), 32'd0);
      checkOutput("midreset_data", data_o, 32'd0);
      checkOutput("midreset_busy", 32'(busy_o), 32'd0);
      checkOutput("midreset_mosi", 32'(mosi_o), 32'd0);
      @(negedge clk_i);
      reset_n_i = 1'b1;
      busy_seen = 0;
      repeat (20) begin
         @(negedge clk_i);
         if (busy_o || sclk_o) busy_seen++;
      end
      checkOutput("idle_after_midreset", 32'(busy_seen), 32'd0);

      runTransfer(vecs[1], 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
